chrom_serializer: RTL and testbench
===================================

CHROM_SERIALIZER -- requirements
Module: chrom_serializer

Interface
REQ-001 SHALL provide parameter NUM_SEGS, default 4, meaning the number of 32-bit segments per chromosome (legal range 1..255).
REQ-002 SHALL provide parameter DIV, default 1, meaning clock cycles per serial bit (legal range 1..255).
REQ-003 SHALL have one clock and a synchronous active-high reset, with ports named clk and reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 seg_data  input  32  chromosome segment word, driven from the chromosome-segment PIO out_port.
REQ-007 seg_valid  input  1  seg_data holds a new segment.
REQ-008 seg_ready  output  1  block can accept a segment this cycle.
REQ-009 start  input  1  one-cycle pulse that begins a new chromosome load.
REQ-010 ser_data  output  1  serial config bit to the genetic circuit chain.
REQ-011 ser_en  output  1  one-cycle shift strobe; ser_data is valid when ser_en=1.
REQ-012 seg_count  output  8  number of segments fully shifted since the last start or reset.
REQ-013 busy  output  1  high while in SHIFT.
REQ-014 done  output  1  high in DONE; all NUM_SEGS segments have been shifted.

Function
REQ-015 SHALL implement the states IDLE, SHIFT and DONE.
REQ-016 seg_ready SHALL be (state==IDLE) && !start; it is combinational.
REQ-017 A segment SHALL be accepted on the edge where seg_valid && seg_ready; at that edge seg_data is captured into a 32-bit shift register, the bit counter is set to 31, the divider is cleared and the state moves to SHIFT.
REQ-018 seg_valid without seg_ready SHALL have no effect, and seg_data SHALL NOT be sampled.
REQ-019 In SHIFT, the divider SHALL count 0..DIV-1; ser_en SHALL be 1 for exactly the one cycle in which divider==DIV-1, and 0 otherwise.
REQ-020 ser_data SHALL equal shreg[31] (MSB first); the register shifts left by 1 on each ser_en cycle.
REQ-021 The first ser_en SHALL occur DIV cycles after the acceptance edge, and successive ser_en pulses SHALL be spaced DIV cycles apart; for DIV=1, ser_en is high for 32 consecutive cycles.
REQ-022 On the ser_en cycle with bit counter==0, seg_count SHALL increment at that edge; the next state is DONE if the new seg_count equals NUM_SEGS, else IDLE.
REQ-023 seg_count SHALL never exceed NUM_SEGS and SHALL NOT wrap.
REQ-024 In DONE, seg_ready SHALL be 0; start returns the block to IDLE and clears seg_count and done.
REQ-025 start in IDLE SHALL clear seg_count; start in SHIFT SHALL be ignored.
REQ-026 When start and seg_valid are asserted in the same IDLE cycle, start SHALL win and the segment SHALL NOT be accepted.
REQ-027 busy SHALL be (state==SHIFT); done SHALL be (state==DONE); both are registered-state decodes.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set state=IDLE, shreg=0, bit counter=0, divider=0 and seg_count=0.
REQ-029 After reset, outputs SHALL be ser_en=0, ser_data=0, busy=0, done=0, seg_count=0 and seg_ready=1 (start=0).
REQ-030 reset SHALL override start, seg_valid and any in-progress shift; a partial segment is discarded and no further ser_en is issued.

Configuration
REQ-031 When macro CHROM_SER_CRC_EN is defined, the block SHALL add output crc_out (8 bits) holding a CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) updated with ser_data on every ser_en cycle.
REQ-032 crc_out SHALL be cleared by reset and by any accepted start.
REQ-033 When CHROM_SER_CRC_EN is undefined, the crc_out port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset scenario: hold reset 2 cycles, then release with inputs idle -> seg_ready=1, ser_en=0, busy=0, done=0, seg_count=0.
REQ-035 Single-segment scenario, DIV=1, NUM_SEGS=1: accept 0x80000001 -> ser_en high for 32 consecutive cycles starting 1 cycle after acceptance; ser_data sequence is 1, thirty 0s, 1; seg_count=1; done=1 on the following cycle.
REQ-036 Divider scenario, DIV=3: accept 0xA5A5A5A5 -> 32 ser_en pulses exactly 3 cycles apart; bits 1010_0101 repeated; busy high for 96 cycles.
REQ-037 Multi-segment scenario, NUM_SEGS=4: offer 4 words with seg_valid held constantly -> seg_count steps 1, 2, 3, 4; done=1; a 5th seg_valid is not accepted; start pulse -> IDLE with seg_count=0.
REQ-038 Conflict scenario: start and seg_valid together in IDLE -> no acceptance and busy stays 0; reset asserted mid-SHIFT after 10 bits -> next cycle all outputs at reset values and no further ser_en.
REQ-039 CRC scenario, CHROM_SER_CRC_EN defined: accept 0x00000001 with NUM_SEGS=1 -> crc_out=0x07 after the 32nd bit; start pulse -> crc_out=0x00.

Source files
------------

// File: rtl/chrom_serializer.sv
// Chromosome serializer: loads 32-bit segments and shifts them MSB-first to the config chain.
// Optional CRC-8 over the serial stream when CHROM_SER_CRC_EN is defined (adds crc_out).
module chrom_serializer #(
  parameter int NUM_SEGS = 4,
  parameter int DIV      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seg_data,
  input  logic        seg_valid,
  output logic        seg_ready,
  input  logic        start,
  output logic        ser_data,
  output logic        ser_en,
  output logic [7:0]  seg_count,
  output logic        busy,
  output logic        done
`ifdef CHROM_SER_CRC_EN
  ,
  output logic [7:0]  crc_out
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [7:0] SEGS_MAX = 8'(NUM_SEGS);

  state_t      state, state_nx;
  logic [31:0] shreg;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        accept, last_bit, clear_cnt;

  assign seg_ready = (state == IDLE) && !start;
  assign accept    = seg_valid && seg_ready;
  assign ser_en    = (state == SHIFT) && (div_cnt == DIV_LAST);
  assign ser_data  = shreg[31];
  assign last_bit  = ser_en && (bit_cnt == 5'd0);
  // start is only honoured outside SHIFT; it restarts the chromosome count
  assign clear_cnt = start && (state != SHIFT);
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = SHIFT;
      SHIFT: if (last_bit) state_nx = (seg_count + 8'd1 == SEGS_MAX) ? DONE : IDLE;
      DONE:  if (start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (accept) begin
      shreg   <= seg_data;
      bit_cnt <= 5'd31;
      div_cnt <= '0;
    end else if (state == SHIFT) begin
      if (ser_en) begin
        shreg   <= {shreg[30:0], 1'b0};
        bit_cnt <= bit_cnt - 5'd1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_cnt)
      seg_count <= '0;
    else if (last_bit && seg_count != SEGS_MAX)
      seg_count <= seg_count + 8'd1;
  end

`ifdef CHROM_SER_CRC_EN
  // CRC-8, poly 0x07, one bit per shift strobe
  logic crc_fb;
  assign crc_fb = crc_out[7] ^ ser_data;

  always_ff @(posedge clk) begin
    if (reset || clear_cnt)
      crc_out <= '0;
    else if (ser_en)
      crc_out <= {crc_out[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  end
`endif

endmodule

// File: tb/tb_chrom_serializer.sv
// Bench for chrom_serializer: two instances (DIV=1/NUM_SEGS=1 and DIV=3/NUM_SEGS=4) with bit scoreboards.
module tb_chrom_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_reset, a_seg_valid, a_start, a_seg_ready, a_ser_data, a_ser_en, a_busy, a_done;
  logic [31:0] a_seg_data;
  logic [7:0]  a_seg_count;
  logic        b_reset, b_seg_valid, b_start, b_seg_ready, b_ser_data, b_ser_en, b_busy, b_done;
  logic [31:0] b_seg_data;
  logic [7:0]  b_seg_count;
`ifdef CHROM_SER_CRC_EN
  logic [7:0]  a_crc, b_crc;
`endif

  chrom_serializer #(.NUM_SEGS(1), .DIV(1)) u_a (
    .clk(clk), .reset(a_reset), .seg_data(a_seg_data), .seg_valid(a_seg_valid),
    .seg_ready(a_seg_ready), .start(a_start), .ser_data(a_ser_data), .ser_en(a_ser_en),
    .seg_count(a_seg_count), .busy(a_busy), .done(a_done)
`ifdef CHROM_SER_CRC_EN
    , .crc_out(a_crc)
`endif
  );

  chrom_serializer #(.NUM_SEGS(4), .DIV(3)) u_b (
    .clk(clk), .reset(b_reset), .seg_data(b_seg_data), .seg_valid(b_seg_valid),
    .seg_ready(b_seg_ready), .start(b_start), .ser_data(b_ser_data), .ser_en(b_ser_en),
    .seg_count(b_seg_count), .busy(b_busy), .done(b_done)
`ifdef CHROM_SER_CRC_EN
    , .crc_out(b_crc)
`endif
  );

  // Expected serial bits, MSB first, pushed when a segment is offered
  bit qa[$];
  bit qb[$];
  bit ea, eb;

  task automatic push_a(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) qa.push_back(w[i]);
  endtask

  task automatic push_b(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) qb.push_back(w[i]);
  endtask

  always @(negedge clk) begin
    if (a_ser_en === 1'b1) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_ser_stream: ser_en=1 with no bit expected");
      end else begin
        ea = qa.pop_front();
        if (a_ser_data !== ea) begin
          errors++;
          $display("FAIL a_ser_data: got %b exp %b", a_ser_data, ea);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_ser_en === 1'b1) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_ser_stream: ser_en=1 with no bit expected");
      end else begin
        eb = qb.pop_front();
        if (b_ser_data !== eb) begin
          errors++;
          $display("FAIL b_ser_data: got %b exp %b", b_ser_data, eb);
        end
      end
    end
  end

  task automatic test_reset;
    a_reset = 1; b_reset = 1;
    a_seg_valid = 0; a_start = 0; a_seg_data = '0;
    b_seg_valid = 0; b_start = 0; b_seg_data = '0;
    repeat (2) @(posedge clk);
    #1 a_reset = 0; b_reset = 0;
    @(negedge clk);
    checks++;
    if ({a_seg_ready, a_ser_en, a_ser_data, a_busy, a_done, a_seg_count} !== {5'b10000, 8'd0}) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b en=%b d=%b busy=%b done=%b cnt=%0d exp 1 0 0 0 0 0",
               a_seg_ready, a_ser_en, a_ser_data, a_busy, a_done, a_seg_count);
    end
    checks++;
    if ({b_seg_ready, b_ser_en, b_ser_data, b_busy, b_done, b_seg_count} !== {5'b10000, 8'd0}) begin
      errors++;
      $display("FAIL reset_b: got rdy=%b en=%b d=%b busy=%b done=%b cnt=%0d exp 1 0 0 0 0 0",
               b_seg_ready, b_ser_en, b_ser_data, b_busy, b_done, b_seg_count);
    end
  endtask

  task automatic test_single;
    int run;
    @(posedge clk); #1 a_seg_data = 32'h8000_0001; a_seg_valid = 1;
    push_a(32'h8000_0001);
    @(negedge clk);
    checks++;
    if (a_seg_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", a_seg_ready); end
    @(posedge clk); #1 a_seg_valid = 0; a_seg_data = 32'hFFFF_FFFF;
    run = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (a_ser_en === 1'b1 && a_busy === 1'b1) run++;
    end
    checks++;
    if (run != 32) begin errors++; $display("FAIL single_run: got %0d consecutive ser_en exp 32", run); end
    @(negedge clk);
    checks++;
    if ({a_ser_en, a_done, a_busy, a_seg_ready, a_seg_count} !== {4'b0100, 8'd1}) begin
      errors++;
      $display("FAIL single_done: got en=%b done=%b busy=%b rdy=%b cnt=%0d exp 0 1 0 0 1",
               a_ser_en, a_done, a_busy, a_seg_ready, a_seg_count);
    end
    checks++;
    if (qa.size() != 0) begin errors++; $display("FAIL single_drain: got %0d bits left exp 0", qa.size()); end
    a_seg_valid = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b1 || a_seg_count !== 8'd1) begin
        errors++;
        $display("FAIL single_hold: got busy=%b done=%b cnt=%0d exp 0 1 1", a_busy, a_done, a_seg_count);
      end
    end
    @(posedge clk); #1 a_start = 1; a_seg_valid = 0;
    @(posedge clk); #1 a_start = 0;
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_seg_count !== 8'd0 || a_seg_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_restart: got done=%b cnt=%0d rdy=%b exp 0 0 1", a_done, a_seg_count, a_seg_ready);
    end
  endtask

  task automatic test_divider;
    int n, busy_cnt, last;
    @(posedge clk); #1 b_seg_data = 32'hA5A5_A5A5; b_seg_valid = 1;
    push_b(32'hA5A5_A5A5);
    @(posedge clk); #1 b_seg_valid = 0; b_seg_data = '0;
    n = 0; busy_cnt = 0; last = 0;
    for (int cyc = 1; cyc <= 110; cyc++) begin
      @(negedge clk);
      if (b_busy === 1'b1) busy_cnt++;
      if (b_ser_en === 1'b1) begin
        checks++;
        if (cyc - last != 3) begin
          errors++;
          $display("FAIL div_spacing: got %0d cycles exp 3 (pulse %0d)", cyc - last, n);
        end
        last = cyc;
        n++;
      end
    end
    checks++;
    if (n != 32) begin errors++; $display("FAIL div_pulses: got %0d exp 32", n); end
    checks++;
    if (busy_cnt != 96) begin errors++; $display("FAIL div_busy: got %0d cycles exp 96", busy_cnt); end
    checks++;
    if (b_seg_count !== 8'd1 || b_done !== 1'b0 || b_seg_ready !== 1'b1) begin
      errors++;
      $display("FAIL div_end: got cnt=%0d done=%b rdy=%b exp 1 0 1", b_seg_count, b_done, b_seg_ready);
    end
  endtask

  task automatic test_multi;
    logic [31:0] w [4];
    int guard;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    @(posedge clk); #1 b_start = 1;
    @(posedge clk); #1 b_start = 0;
    @(negedge clk);
    checks++;
    if (b_seg_count !== 8'd0) begin errors++; $display("FAIL multi_clear: got %0d exp 0", b_seg_count); end
    b_seg_valid = 1; b_seg_data = w[0];
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b_seg_ready !== 1'b1 || b_seg_count !== 8'(k)) begin
        errors++;
        $display("FAIL multi_step: got rdy=%b cnt=%0d exp 1 %0d", b_seg_ready, b_seg_count, k);
      end
      push_b(w[k]);
      @(posedge clk); #1 if (k < 3) b_seg_data = w[k+1];
      guard = 0;
      @(negedge clk);
      while (b_busy === 1'b1 && guard < 200) begin @(negedge clk); guard++; end
      checks++;
      if (guard >= 200) begin errors++; $display("FAIL multi_timeout: busy stuck at segment %0d", k); end
    end
    checks++;
    if (b_done !== 1'b1 || b_seg_count !== 8'd4 || b_seg_ready !== 1'b0) begin
      errors++;
      $display("FAIL multi_done: got done=%b cnt=%0d rdy=%b exp 1 4 0", b_done, b_seg_count, b_seg_ready);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (b_busy !== 1'b0 || b_seg_count !== 8'd4) begin
        errors++;
        $display("FAIL multi_fifth: got busy=%b cnt=%0d exp 0 4", b_busy, b_seg_count);
      end
    end
    @(posedge clk); #1 b_start = 1; b_seg_valid = 0;
    @(posedge clk); #1 b_start = 0;
    @(negedge clk);
    checks++;
    if (b_seg_count !== 8'd0 || b_done !== 1'b0 || b_seg_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_restart: got cnt=%0d done=%b rdy=%b exp 0 0 1", b_seg_count, b_done, b_seg_ready);
    end
  endtask

  task automatic test_conflict;
    logic [31:0] w;
    int n, guard, stray;
    @(posedge clk); #1 b_start = 1; b_seg_valid = 1; b_seg_data = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (b_seg_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready: got %b exp 0", b_seg_ready); end
    @(posedge clk); #1 b_start = 0; b_seg_valid = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (b_busy !== 1'b0) begin errors++; $display("FAIL conflict_busy: got %b exp 0", b_busy); end
    end
    w = $urandom;
    @(posedge clk); #1 b_seg_data = w; b_seg_valid = 1;
    push_b(w);
    @(posedge clk); #1 b_seg_valid = 0;
    n = 0; guard = 0;
    while (n < 10 && guard < 100) begin
      @(negedge clk);
      if (b_ser_en === 1'b1) n++;
      guard++;
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL midshift_bits: got %0d exp 10", n); end
    b_reset = 1;
    @(negedge clk);
    qb.delete();
    checks++;
    if ({b_seg_ready, b_ser_en, b_ser_data, b_busy, b_done, b_seg_count} !== {5'b10000, 8'd0}) begin
      errors++;
      $display("FAIL midshift_reset: got rdy=%b en=%b d=%b busy=%b done=%b cnt=%0d exp 1 0 0 0 0 0",
               b_seg_ready, b_ser_en, b_ser_data, b_busy, b_done, b_seg_count);
    end
    b_reset = 0;
    stray = 0;
    repeat (100) begin
      @(negedge clk);
      if (b_ser_en !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL midshift_stray: got %0d ser_en after reset exp 0", stray); end
  endtask

`ifdef CHROM_SER_CRC_EN
  function automatic logic [7:0] crc8(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ w[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  task automatic test_crc;
    logic [31:0] w [2];
    int guard;
    w[0] = 32'h0000_0001;
    w[1] = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 a_seg_data = w[k]; a_seg_valid = 1;
      push_a(w[k]);
      @(posedge clk); #1 a_seg_valid = 0;
      guard = 0;
      @(negedge clk);
      while (a_done !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      checks++;
      if (a_crc !== crc8(w[k])) begin
        errors++;
        $display("FAIL crc_value: word %h got %h exp %h", w[k], a_crc, crc8(w[k]));
      end
      @(posedge clk); #1 a_start = 1;
      @(posedge clk); #1 a_start = 0;
      @(negedge clk);
      checks++;
      if (a_crc !== 8'h00) begin errors++; $display("FAIL crc_clear: got %h exp 00", a_crc); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_divider();
    test_multi();
    test_conflict();
`ifdef CHROM_SER_CRC_EN
    test_crc();
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
